// File: rtl/cvxif_instr_pkg.sv
// Shared CV-X-IF coprocessor definitions: instruction table,
// issue-queue entry layout and scheduler FSM states.
package cvxif_instr_pkg;

  localparam int unsigned NumInstr = 4;
  localparam int unsigned IdMax    = 8;
  localparam int unsigned XLenMax  = 64;

  // Index 0 is the rightmost element; lower index wins on overlap.
  localparam logic [NumInstr-1:0][31:0] InstrTbl = {
    32'h0000_000B,
    32'h0000_002B,
    32'h0000_005B,
    32'h0000_105B
  };

  localparam logic [NumInstr-1:0][31:0] MaskTbl = {
    32'h0000_007F,
    32'h0000_007F,
    32'h0000_007F,
    32'h0000_707F
  };

  localparam logic [NumInstr-1:0] WbTbl = 4'b1010;

  typedef struct packed {
    logic [31:0]         instr;
    logic [IdMax-1:0]    id;
    logic [XLenMax-1:0]  rs1;
    logic [XLenMax-1:0]  rs2;
    logic                writeback;
    logic                valid;
    logic                committed;
    logic                killed;
  } sched_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    WAIT_FU,
    WAIT_RESULT
  } sched_state_e;

endpackage

// File: rtl/copro_issue_scheduler_if.sv
// Bundle of issue, commit, FU and result signals between
// the core-side environment and the issue scheduler.
interface copro_issue_scheduler_if #(
  parameter int unsigned IdWidth = 3,
  parameter int unsigned XLen    = 64
);

  logic               issue_valid_i;
  logic               issue_ready_o;
  logic [31:0]        issue_instr_i;
  logic [IdWidth-1:0] issue_id_i;
  logic [XLen-1:0]    issue_rs1_i;
  logic [XLen-1:0]    issue_rs2_i;
  logic               issue_accept_o;
  logic               issue_writeback_o;

  logic               commit_valid_i;
  logic [IdWidth-1:0] commit_id_i;
  logic               commit_kill_i;

  logic               fu_req_valid_o;
  logic               fu_req_ready_i;
  logic [31:0]        fu_instr_o;
  logic [IdWidth-1:0] fu_id_o;
  logic [XLen-1:0]    fu_rs1_o;
  logic [XLen-1:0]    fu_rs2_o;

  logic               fu_rsp_valid_i;
  logic [IdWidth-1:0] fu_rsp_id_i;
  logic [XLen-1:0]    fu_rsp_data_i;

  logic               result_valid_o;
  logic               result_ready_i;
  logic [IdWidth-1:0] result_id_o;
  logic [4:0]         result_rd_o;
  logic [XLen-1:0]    result_data_o;
  logic               result_we_o;

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i,
    input  issue_rs1_i, issue_rs2_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    output fu_req_valid_o, fu_instr_o, fu_id_o,
    output fu_rs1_o, fu_rs2_o,
    input  fu_req_ready_i,
    input  fu_rsp_valid_i, fu_rsp_id_i, fu_rsp_data_i,
    output result_valid_o, result_id_o, result_rd_o,
    output result_data_o, result_we_o,
    input  result_ready_i
  );

  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i,
    output issue_rs1_i, issue_rs2_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o,
    output commit_valid_i, commit_id_i, commit_kill_i,
    input  fu_req_valid_o, fu_instr_o, fu_id_o,
    input  fu_rs1_o, fu_rs2_o,
    output fu_req_ready_i,
    output fu_rsp_valid_i, fu_rsp_id_i, fu_rsp_data_i,
    input  result_valid_o, result_id_o, result_rd_o,
    input  result_data_o, result_we_o,
    output result_ready_i
  );

endinterface

// File: rtl/copro_instr_decode.sv
// Combinational match of an instruction word against the
// shared coprocessor table; lowest matching entry wins.
module copro_instr_decode
  import cvxif_instr_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic        o_accept,
  output logic        o_writeback
);

  logic [NumInstr-1:0] w_hit;
  logic [NumInstr-1:0] w_first;

  for (genvar k = 0; k < NumInstr; k++) begin : g_match
    assign w_hit[k] =
      (i_instr & MaskTbl[k]) == InstrTbl[k];
  end

  // Isolate the lowest set bit to get priority.
  assign w_first = w_hit & (~w_hit + NumInstr'(1));

  assign o_accept    = |w_hit;
  assign o_writeback = |(w_first & WbTbl);

endmodule

// File: rtl/copro_issue_scheduler.sv
// In-order issue queue and single-outstanding dispatcher
// between a CV-X-IF core and one coprocessor FU.
module copro_issue_scheduler
  import cvxif_instr_pkg::*;
#(
  parameter int unsigned QDepth  = 4,
  parameter int unsigned IdWidth = 3,
  parameter int unsigned XLen    = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  copro_issue_scheduler_if.slave io
);

  localparam int unsigned PtrW = $clog2(QDepth);
  localparam int unsigned CntW = PtrW + 1;

  sched_entry_t       w_q [QDepth];
  sched_entry_t       w_head;
  sched_entry_t       w_new;
  logic [PtrW-1:0]    r_head;
  logic [PtrW-1:0]    r_tail;
  logic [CntW-1:0]    r_cnt;
  sched_state_e       r_state;
  sched_state_e       w_state_nxt;

  logic [IdWidth-1:0] r_disp_id;
  logic               r_disp_wb;
  logic [4:0]         r_disp_rd;
  logic [IdWidth-1:0] r_res_id;
  logic [4:0]         r_res_rd;
  logic [XLen-1:0]    r_res_data;
  logic               r_res_we;

  logic w_accept;
  logic w_wb;
  logic w_ready;
  logic w_enq;
  logic w_cmt_new;
  logic w_pop_kill;
  logic w_pop_disp;
  logic w_pop;
  logic w_fu_hit;
  logic w_unused;

  copro_instr_decode u_dec (
    .i_instr     (io.issue_instr_i),
    .o_accept    (w_accept),
    .o_writeback (w_wb)
  );

  assign w_ready = r_cnt < CntW'(QDepth);
  assign w_enq   = io.issue_valid_i & w_ready & w_accept;
  assign w_head  = w_q[r_head];
  assign w_unused = ^w_head;

  assign w_cmt_new = io.commit_valid_i &
    (io.commit_id_i == io.issue_id_i);

  always_comb begin
    w_new           = '0;
    w_new.instr     = io.issue_instr_i;
    w_new.id        = IdMax'(io.issue_id_i);
    w_new.rs1       = XLenMax'(io.issue_rs1_i);
    w_new.rs2       = XLenMax'(io.issue_rs2_i);
    w_new.writeback = w_wb;
    w_new.valid     = 1'b1;
    w_new.committed = w_cmt_new & ~io.commit_kill_i;
    w_new.killed    = w_cmt_new & io.commit_kill_i;
  end

  // A killed head drains unless it is already being dispatched.
  assign w_pop_kill = w_head.valid & w_head.killed &
    (r_state != DISPATCH);
  assign w_pop_disp = (r_state == DISPATCH) &
    io.fu_req_ready_i;
  assign w_pop = w_pop_kill | w_pop_disp;

  assign w_fu_hit = (r_state == WAIT_FU) &
    io.fu_rsp_valid_i & (io.fu_rsp_id_i == r_disp_id);

  for (genvar g = 0; g < QDepth; g++) begin : g_ent
    sched_entry_t r_ent;
    logic         w_hit;
    logic         w_wr;
    logic         w_clr;

    assign w_hit = io.commit_valid_i & r_ent.valid &
      (r_ent.id[IdWidth-1:0] == io.commit_id_i);
    assign w_wr  = w_enq & (r_tail == PtrW'(g));
    assign w_clr = w_pop & (r_head == PtrW'(g));

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_ent <= '0;
      end else if (w_wr) begin
        r_ent <= w_new;
      end else begin
        if (w_hit & io.commit_kill_i)
          r_ent.killed <= 1'b1;
        if (w_hit & ~io.commit_kill_i)
          r_ent.committed <= 1'b1;
        if (w_clr)
          r_ent.valid <= 1'b0;
      end
    end

    assign w_q[g] = r_ent;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_pop) r_head <= r_head + PtrW'(1);
      if (w_enq) r_tail <= r_tail + PtrW'(1);
      r_cnt <= r_cnt + CntW'(w_enq) - CntW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_disp_id  <= '0;
      r_disp_wb  <= 1'b0;
      r_disp_rd  <= '0;
      r_res_id   <= '0;
      r_res_rd   <= '0;
      r_res_data <= '0;
      r_res_we   <= 1'b0;
    end else begin
      if (w_pop_disp) begin
        r_disp_id <= w_head.id[IdWidth-1:0];
        r_disp_wb <= w_head.writeback;
        r_disp_rd <= w_head.instr[11:7];
      end
      if (w_fu_hit & r_disp_wb) begin
        r_res_id   <= io.fu_rsp_id_i;
        r_res_rd   <= r_disp_rd;
        r_res_data <= io.fu_rsp_data_i;
        r_res_we   <= r_disp_wb;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:
        if (w_head.valid & w_head.committed &
            ~w_head.killed)
          w_state_nxt = DISPATCH;
      DISPATCH:
        if (io.fu_req_ready_i)
          w_state_nxt = WAIT_FU;
      WAIT_FU:
        if (w_fu_hit)
          w_state_nxt = r_disp_wb ? WAIT_RESULT : IDLE;
      WAIT_RESULT:
        if (io.result_ready_i)
          w_state_nxt = IDLE;
      default:
        w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    io.issue_ready_o     = w_ready;
    io.issue_accept_o    = w_accept;
    io.issue_writeback_o = w_wb;
    io.fu_req_valid_o    = (r_state == DISPATCH);
    io.fu_instr_o        = w_head.instr;
    io.fu_id_o           = w_head.id[IdWidth-1:0];
    io.fu_rs1_o          = w_head.rs1[XLen-1:0];
    io.fu_rs2_o          = w_head.rs2[XLen-1:0];
    io.result_valid_o    = (r_state == WAIT_RESULT);
    io.result_id_o       = r_res_id;
    io.result_rd_o       = r_res_rd;
    io.result_data_o     = r_res_data;
    io.result_we_o       = (r_state == WAIT_RESULT) &
                           r_res_we;
  end

endmodule

// File: tb/tb_copro_issue_scheduler.sv
// Directed scoreboard bench for copro_issue_scheduler:
// the bench plays core, commit unit, FU and result sink.
module tb_copro_issue_scheduler;
  import cvxif_instr_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  copro_issue_scheduler_if #(
    .IdWidth (3),
    .XLen    (64)
  ) bus ();

  copro_issue_scheduler #(
    .QDepth  (4),
    .IdWidth (3),
    .XLen    (64)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .io    (bus)
  );

  typedef struct {
    logic [2:0]  id;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        we;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] ins,
                       input logic [2:0]  id,
                       input logic [63:0] rs,
                       input logic        acc,
                       input logic        wb,
                       input logic        cmt);
    bus.issue_valid_i = 1'b1;
    bus.issue_instr_i = ins;
    bus.issue_id_i    = id;
    bus.issue_rs1_i   = rs;
    bus.issue_rs2_i   = ~rs;
    if (cmt) begin
      bus.commit_valid_i = 1'b1;
      bus.commit_id_i    = id;
      bus.commit_kill_i  = 1'b0;
    end
    #1;
    chk("issue_ready", bus.issue_ready_o, 1);
    chk("issue_accept", bus.issue_accept_o, acc);
    chk("issue_wb", bus.issue_writeback_o, wb);
    @(negedge clk);
    bus.issue_valid_i  = 1'b0;
    bus.commit_valid_i = 1'b0;
  endtask

  task automatic commit(input logic [2:0] id,
                        input logic kill);
    bus.commit_valid_i = 1'b1;
    bus.commit_id_i    = id;
    bus.commit_kill_i  = kill;
    @(negedge clk);
    bus.commit_valid_i = 1'b0;
    bus.commit_kill_i  = 1'b0;
  endtask

  task automatic wait_fu(input logic [2:0]  id,
                         input logic [31:0] ins,
                         input logic [63:0] rs);
    int n = 0;
    while (bus.fu_req_valid_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fu_req_seen", bus.fu_req_valid_o, 1);
    chk("fu_id", bus.fu_id_o, id);
    chk("fu_instr", bus.fu_instr_o, ins);
    chk("fu_rs1", bus.fu_rs1_o, rs);
    chk("fu_rs2", bus.fu_rs2_o, ~rs);
    bus.fu_req_ready_i = 1'b1;
    @(negedge clk);
    bus.fu_req_ready_i = 1'b0;
  endtask

  task automatic fu_rsp(input logic [2:0]  id,
                        input logic [63:0] data,
                        input logic        push,
                        input logic [4:0]  rd);
    exp_t e;
    if (push) begin
      e.id   = id;
      e.rd   = rd;
      e.data = data;
      e.we   = 1'b1;
      sb.push_back(e);
    end
    bus.fu_rsp_valid_i = 1'b1;
    bus.fu_rsp_id_i    = id;
    bus.fu_rsp_data_i  = data;
    @(negedge clk);
    bus.fu_rsp_valid_i = 1'b0;
  endtask

  task automatic wait_valid_result();
    int n = 0;
    while (bus.result_valid_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("result_seen", bus.result_valid_o, 1);
  endtask

  task automatic take_result();
    exp_t e;
    wait_valid_result();
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("result_id", bus.result_id_o, e.id);
      chk("result_rd", bus.result_rd_o, e.rd);
      chk("result_data", bus.result_data_o, e.data);
      chk("result_we", bus.result_we_o, e.we);
    end
    bus.result_ready_i = 1'b1;
    @(negedge clk);
    bus.result_ready_i = 1'b0;
    chk("result_drop", bus.result_valid_o, 0);
  endtask

  task automatic quiet_result(input string tag);
    logic seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | bus.result_valid_o;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                = 1'b1;
    bus.issue_valid_i  = 1'b0;
    bus.issue_instr_i  = '0;
    bus.issue_id_i     = '0;
    bus.issue_rs1_i    = '0;
    bus.issue_rs2_i    = '0;
    bus.commit_valid_i = 1'b0;
    bus.commit_id_i    = '0;
    bus.commit_kill_i  = 1'b0;
    bus.fu_req_ready_i = 1'b0;
    bus.fu_rsp_valid_i = 1'b0;
    bus.fu_rsp_id_i    = '0;
    bus.fu_rsp_data_i  = '0;
    bus.result_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.issue_ready_o, 1);
    chk("rst_fu_valid", bus.fu_req_valid_o, 0);
    chk("rst_res_valid", bus.result_valid_o, 0);
    chk("rst_res_we", bus.result_we_o, 0);
    chk("rst_cnt", dut.r_cnt, 0);
    chk("rst_state", dut.r_state, IDLE);

    // custom-2 with writeback, committed one cycle later
    issue(32'h0000_005B, 3'd1, 64'h10, 1, 1, 0);
    commit(3'd1, 1'b0);
    wait_fu(3'd1, 32'h0000_005B, 64'h10);
    fu_rsp(3'd1, 64'hAB, 1'b1, 5'd0);
    take_result();

    // no-writeback instruction, commit in the issue cycle
    issue(32'h0000_002B, 3'd2, 64'h20, 1, 0, 1);
    wait_fu(3'd2, 32'h0000_002B, 64'h20);
    fu_rsp(3'd2, 64'h55, 1'b0, 5'd0);
    quiet_result("nowb_no_result");
    chk("nowb_state", dut.r_state, IDLE);

    // unknown opcode completes handshake, not queued
    issue(32'h0000_0033, 3'd3, 64'h30, 0, 0, 0);
    chk("reject_cnt", dut.r_cnt, 0);
    chk("reject_fu", bus.fu_req_valid_o, 0);

    // fill the queue; first entry checks lowest-index priority
    issue(32'h0000_105B, 3'd4, 64'h40, 1, 0, 0);
    issue(32'h0000_02DB, 3'd5, 64'h50, 1, 1, 0);
    issue(32'h0000_002B, 3'd6, 64'h60, 1, 0, 0);
    issue(32'h0000_005B, 3'd7, 64'h70, 1, 1, 0);
    chk("full_ready", bus.issue_ready_o, 0);
    chk("full_cnt", dut.r_cnt, 4);
    commit(3'd4, 1'b1);
    chk("kill_ready_t1", bus.issue_ready_o, 0);
    chk("kill_fu_t1", bus.fu_req_valid_o, 0);
    @(negedge clk);
    chk("kill_ready_t2", bus.issue_ready_o, 1);
    chk("kill_cnt", dut.r_cnt, 3);
    chk("kill_fu_t2", bus.fu_req_valid_o, 0);

    // result back-pressure holds fields and blocks dispatch
    commit(3'd5, 1'b0);
    commit(3'd6, 1'b0);
    commit(3'd7, 1'b0);
    wait_fu(3'd5, 32'h0000_02DB, 64'h50);
    fu_rsp(3'd5, 64'h1111, 1'b1, 5'd5);
    wait_valid_result();
    repeat (5) begin
      chk("hold_valid", bus.result_valid_o, 1);
      chk("hold_id", bus.result_id_o, 5);
      chk("hold_rd", bus.result_rd_o, 5);
      chk("hold_data", bus.result_data_o, 64'h1111);
      chk("hold_no_fu", bus.fu_req_valid_o, 0);
      @(negedge clk);
    end
    take_result();
    wait_fu(3'd6, 32'h0000_002B, 64'h60);
    fu_rsp(3'd6, 64'h66, 1'b0, 5'd0);
    wait_fu(3'd7, 32'h0000_005B, 64'h70);
    fu_rsp(3'd3, 64'hDEAD, 1'b0, 5'd0);
    chk("wrong_id_state", dut.r_state, WAIT_FU);
    fu_rsp(3'd7, 64'h7777, 1'b1, 5'd0);
    take_result();
    chk("drain_cnt", dut.r_cnt, 0);

    // reset while the FU owns an instruction
    issue(32'h0000_005B, 3'd1, 64'h80, 1, 1, 1);
    wait_fu(3'd1, 32'h0000_005B, 64'h80);
    chk("pre_rst_state", dut.r_state, WAIT_FU);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_state", dut.r_state, IDLE);
    chk("mid_rst_cnt", dut.r_cnt, 0);
    chk("mid_rst_ready", bus.issue_ready_o, 1);
    chk("mid_rst_data", bus.result_data_o, 0);
    fu_rsp(3'd1, 64'hBAD, 1'b0, 5'd0);
    quiet_result("stale_rsp");
    chk("stale_state", dut.r_state, IDLE);
    chk("stale_fu", bus.fu_req_valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
